gpr_file_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the pipelined MIPS core, succeeding the single-write, two-read GPR. It provides NRD combinational read ports and two prioritised write ports, with optional write-to-read bypass. A flag register shares the register address space and supports a sticky-OR mode. A per-register busy scoreboard lets the decode stage detect RAW hazards against in-flight producers.

---
 rtl/gpr_file_mp_pkg.sv | 17 +
 rtl/gpr_scoreboard.sv | 50 +++++
 rtl/gpr_file_mp.sv | 142 ++++++++++++++
 tb/tb_gpr_file_mp.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_file_mp_pkg.sv
// Shared constants for the multi-port GPR file: flag operation encodings,
// write-enable levels and the default flag register index.
package gpr_file_mp_pkg;

  typedef enum logic [1:0] {
    FLAG_OP_DIS        = 2'b00,
    FLAG_OP_SET        = 2'b01,
    FLAG_OP_SET_AND_WR = 2'b10,
    FLAG_OP_OR         = 2'b11
  } flag_op_e;

  localparam logic WR_EN  = 1'b1;
  localparam logic WR_DIS = 1'b0;

  localparam int REG_ADDR_FLAG = 31;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard: issue sets a bit, a write-back clears it,
// a same-cycle issue beats the clear, and register 0 is never busy.
module gpr_scoreboard
  import gpr_file_mp_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic [1:0]        clr_en,
  input  logic [AW-1:0]     clr_addr0,
  input  logic [AW-1:0]     clr_addr1,
  output logic [2**AW-1:0]  busy
);

  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;

  // next busy vector: set has priority over either clear
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 1; i < DEPTH; i++) begin
      if ((set_en == WR_EN) && (set_addr == AW'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (((clr_en[0] == WR_EN) && (clr_addr0 == AW'(i))) ||
                   ((clr_en[1] == WR_EN) && (clr_addr1 == AW'(i)))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // busy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: NRD combinational read ports, two prioritised write
// ports with optional bypass, an aliased flag register and a busy scoreboard.
module gpr_file_mp
  import gpr_file_mp_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int NRD       = 2,
  parameter int BYPASS    = 1,
  parameter int FLAG_ADDR = REG_ADDR_FLAG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] A,
  output logic [NRD*DW-1:0] RD,
  output logic [NRD-1:0]    RBusy,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [AW-1:0]     AWr0,
  input  logic [AW-1:0]     AWr1,
  input  logic [DW-1:0]     Din0,
  input  logic [DW-1:0]     Din1,
  input  logic [1:0]        FlagOp,
  input  logic [DW-1:0]     NFlag,
  output logic [DW-1:0]     Flag,
  input  logic              IssueEn,
  input  logic [AW-1:0]     IssueAddr
);

  localparam int            DEPTH    = 2**AW;
  localparam logic [AW-1:0] FLAG_IDX = AW'(FLAG_ADDR);
  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

  if ((NRD < 1) || (NRD > 4)) begin : g_bad_nrd
    $error("gpr_file_mp: NRD must be in 1..4");
  end

  flag_op_e         flag_op_s;
  logic             flag_claim_s;
  logic             data_hold_s;
  logic [1:0]       wr_ok_s;
  logic [DW-1:0]    regs_r     [DEPTH];
  logic [DW-1:0]    regs_nxt_s [DEPTH];
  logic [DEPTH-1:0] busy_s;

  assign flag_op_s    = flag_op_e'(FlagOp);
  assign flag_claim_s = (flag_op_s != FLAG_OP_DIS);
  // a plain SET owns the cycle: data writes are held off entirely
  assign data_hold_s  = (flag_op_s == FLAG_OP_SET);

  // a write is effective only if it really commits: never r0, never while a
  // flag op owns FLAG_ADDR, never in reset (so bypass cannot leak data then)
  assign wr_ok_s[0] = reset && (WE0 == WR_EN) && (AWr0 != ZERO_IDX) && !data_hold_s &&
                      !(flag_claim_s && (AWr0 == FLAG_IDX));
  assign wr_ok_s[1] = reset && (WE1 == WR_EN) && (AWr1 != ZERO_IDX) && !data_hold_s &&
                      !(flag_claim_s && (AWr1 == FLAG_IDX));

  // next register contents: port 1 over port 0, then the flag operation
  always_comb begin
    regs_nxt_s = regs_r;
    for (int i = 1; i < DEPTH; i++) begin
      if (wr_ok_s[1] && (AWr1 == AW'(i))) begin
        regs_nxt_s[i] = Din1;
      end else if (wr_ok_s[0] && (AWr0 == AW'(i))) begin
        regs_nxt_s[i] = Din0;
      end else begin
        regs_nxt_s[i] = regs_r[i];
      end
    end
    regs_nxt_s[0] = {DW{1'b0}};
    case (flag_op_s)
      FLAG_OP_SET, FLAG_OP_SET_AND_WR: regs_nxt_s[FLAG_IDX] = NFlag;
      FLAG_OP_OR:                      regs_nxt_s[FLAG_IDX] = regs_r[FLAG_IDX] | NFlag;
      default:                         begin end
    endcase
  end

  // register array state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= regs_nxt_s[i];
      end
    end
  end

  assign Flag = regs_r[FLAG_IDX];

  // scoreboard clears on the raw write enables: the producer has retired
  gpr_scoreboard #(
    .AW (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (reset),
    .set_en    (IssueEn),
    .set_addr  (IssueAddr),
    .clr_en    ({WE1, WE0}),
    .clr_addr0 (AWr0),
    .clr_addr1 (AWr1),
    .busy      (busy_s)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a_s;
    logic [DW-1:0] rd_s;
    logic          rbusy_s;
    logic          hit0_s;
    logic          hit1_s;
    logic          clr_s;
    logic          iss_s;

    assign a_s    = A[k*AW +: AW];
    assign hit0_s = wr_ok_s[0] && (AWr0 == a_s);
    assign hit1_s = wr_ok_s[1] && (AWr1 == a_s);
    assign clr_s  = ((WE0 == WR_EN) && (AWr0 == a_s)) || ((WE1 == WR_EN) && (AWr1 == a_s));
    assign iss_s  = (IssueEn == WR_EN) && (IssueAddr == a_s);

    // read mux with optional forwarding of this cycle's writes
    always_comb begin
      if ((BYPASS != 0) && hit1_s) begin
        rd_s = Din1;
      end else if ((BYPASS != 0) && hit0_s) begin
        rd_s = Din0;
      end else begin
        rd_s = regs_r[a_s];
      end
      if ((BYPASS != 0) && clr_s && !iss_s) begin
        rbusy_s = 1'b0;
      end else begin
        rbusy_s = busy_s[a_s];
      end
    end

    assign RD[k*DW +: DW] = rd_s;
    assign RBusy[k]       = rbusy_s;
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Self-checking bench: a 4-port bypassing instance and a 2-port registered
// instance share write/flag/issue stimulus and are checked against one model.
module tb_gpr_file_mp;
  import gpr_file_mp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [19:0]  a4;
  logic [9:0]   a2;
  logic [127:0] rd4;
  logic [63:0]  rd2;
  logic [3:0]   rbusy4;
  logic [1:0]   rbusy2;
  logic         we0, we1;
  logic [4:0]   awr0, awr1;
  logic [31:0]  din0, din1;
  logic [1:0]   flagop;
  logic [31:0]  nflag, flag4, flag2;
  logic         issue_en;
  logic [4:0]   issue_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic        m_busy [32];

  gpr_file_mp #(.DW(32), .AW(5), .NRD(4), .BYPASS(1), .FLAG_ADDR(31)) u_dut (
    .clk(clk), .reset(reset), .A(a4), .RD(rd4), .RBusy(rbusy4),
    .WE0(we0), .WE1(we1), .AWr0(awr0), .AWr1(awr1), .Din0(din0), .Din1(din1),
    .FlagOp(flagop), .NFlag(nflag), .Flag(flag4),
    .IssueEn(issue_en), .IssueAddr(issue_addr)
  );

  gpr_file_mp #(.DW(32), .AW(5), .NRD(2), .BYPASS(0), .FLAG_ADDR(31)) u_nb (
    .clk(clk), .reset(reset), .A(a2), .RD(rd2), .RBusy(rbusy2),
    .WE0(we0), .WE1(we1), .AWr0(awr0), .AWr1(awr1), .Din0(din0), .Din1(din1),
    .FlagOp(flagop), .NFlag(nflag), .Flag(flag2),
    .IssueEn(issue_en), .IssueAddr(issue_addr)
  );

  // does write port p really land in register a this cycle
  function automatic logic commits(input int p, input logic [4:0] a);
    logic       we;
    logic [4:0] aw;
    we = (p == 1) ? we1 : we0;
    aw = (p == 1) ? awr1 : awr0;
    if (!we || aw != a || a == 5'd0) return 1'b0;
    if (flagop == FLAG_OP_SET) return 1'b0;
    if (a == 5'd31 && flagop != FLAG_OP_DIS) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input int bp, input logic [4:0] a);
    if (bp != 0 && commits(1, a)) return din1;
    if (bp != 0 && commits(0, a)) return din0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int bp, input logic [4:0] a);
    logic written, reissued;
    written  = (we0 && awr0 == a) || (we1 && awr1 == a);
    reissued = issue_en && issue_addr == a;
    if (a == 5'd0) return 1'b0;
    if (bp != 0 && written && !reissued) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [31:0] old_flag;
    old_flag = m_regs[31];
    if (commits(0, awr0)) m_regs[awr0] = din0;
    if (commits(1, awr1)) m_regs[awr1] = din1;
    if (flagop == FLAG_OP_SET || flagop == FLAG_OP_SET_AND_WR) m_regs[31] = nflag;
    if (flagop == FLAG_OP_OR) m_regs[31] = old_flag | nflag;
    if (we0) m_busy[awr0] = 1'b0;
    if (we1) m_busy[awr1] = 1'b0;
    if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic drive_idle();
    we0 = 1'b0; we1 = 1'b0; awr0 = 5'd0; awr1 = 5'd0;
    din0 = 32'h0; din1 = 32'h0; flagop = FLAG_OP_DIS; nflag = 32'h0;
    issue_en = 1'b0; issue_addr = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    we0 = 1'b1; awr0 = 5'd5; din0 = 32'hdead_beef;
    tick();
    drive_idle(); issue_en = 1'b1; issue_addr = 5'd6; flagop = FLAG_OP_SET; nflag = 32'h77;
    tick();
    drive_idle(); a4 = {4{5'd5}};
    #2;
    checks++;
    if (rd4[31:0] !== 32'hdead_beef) begin
      errors++; $display("FAIL pre_reset_r5: got %h want %h", rd4[31:0], 32'hdead_beef);
    end
    we0 = 1'b1; awr0 = 5'd8; din0 = 32'habcd_1234;
    #1 reset = 1'b0;
    model_reset();
    for (int a = 0; a < 32; a++) begin
      a4 = {4{5'(a)}}; a2 = {2{5'(a)}};
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd4[k*32 +: 32] !== 32'h0 || rbusy4[k] !== 1'b0) begin
          errors++; $display("FAIL reset_sweep4 a%0d p%0d: got %h/%b want 0/0", a, k, rd4[k*32 +: 32], rbusy4[k]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rd2[k*32 +: 32] !== 32'h0 || rbusy2[k] !== 1'b0) begin
          errors++; $display("FAIL reset_sweep2 a%0d p%0d: got %h/%b want 0/0", a, k, rd2[k*32 +: 32], rbusy2[k]);
        end
      end
    end
    checks++;
    if (flag4 !== 32'h0 || flag2 !== 32'h0) begin
      errors++; $display("FAIL reset_flag: got %h/%h want 0", flag4, flag2);
    end
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    a4 = {5'd6, 5'd8, 5'd8, 5'd5}; a2 = {5'd8, 5'd5};
    #2;
    checks++;
    if (rd4[63:32] !== 32'h0 || rd2[63:32] !== 32'h0) begin
      errors++; $display("FAIL reset_lost_write: got %h/%h want 0", rd4[63:32], rd2[63:32]);
    end
    checks++;
    if (rd4[31:0] !== 32'h0 || rbusy4[3] !== 1'b0) begin
      errors++; $display("FAIL reset_after: got %h/%b want 0/0", rd4[31:0], rbusy4[3]);
    end
  endtask

  task automatic test_dual_write();
    drive_idle();
    we0 = 1'b1; awr0 = 5'd7; din0 = 32'h1111_1111;
    we1 = 1'b1; awr1 = 5'd7; din1 = 32'h2222_2222;
    a4 = {4{5'd7}}; a2 = {2{5'd7}};
    #2;
    checks++;
    if (rd4[31:0] !== 32'h2222_2222 || rd2[31:0] !== 32'h0) begin
      errors++; $display("FAIL dual_pre_edge: got %h/%h want 22222222/0", rd4[31:0], rd2[31:0]);
    end
    tick();
    drive_idle();
    #2;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd4[k*32 +: 32] !== 32'h2222_2222) begin
        errors++; $display("FAIL dual_port1_wins p%0d: got %h want 22222222", k, rd4[k*32 +: 32]);
      end
    end
    checks++;
    if (rd2[63:32] !== 32'h2222_2222) begin
      errors++; $display("FAIL dual_nb: got %h want 22222222", rd2[63:32]);
    end
    we0 = 1'b1; awr0 = 5'd0; din0 = 32'hffff_ffff; a4 = {4{5'd0}}; a2 = {2{5'd0}};
    #2;
    checks++;
    if (rd4[31:0] !== 32'h0) begin
      errors++; $display("FAIL r0_bypass: got %h want 0", rd4[31:0]);
    end
    tick();
    drive_idle();
    #2;
    checks++;
    if (rd2[31:0] !== 32'h0 || rd4[127:96] !== 32'h0) begin
      errors++; $display("FAIL r0_write: got %h/%h want 0", rd2[31:0], rd4[127:96]);
    end
  endtask

  task automatic test_bypass();
    drive_idle();
    we1 = 1'b1; awr1 = 5'd9; din1 = 32'hfedc_1234;
    a4 = {4{5'd9}}; a2 = {2{5'd9}};
    #2;
    checks++;
    if (rd4[31:0] !== 32'hfedc_1234) begin
      errors++; $display("FAIL bypass_on: got %h want fedc1234", rd4[31:0]);
    end
    checks++;
    if (rd2[31:0] !== 32'h0) begin
      errors++; $display("FAIL bypass_off_old: got %h want 0", rd2[31:0]);
    end
    tick();
    drive_idle();
    #2;
    checks++;
    if (rd2[31:0] !== 32'hfedc_1234) begin
      errors++; $display("FAIL bypass_off_new: got %h want fedc1234", rd2[31:0]);
    end
  endtask

  task automatic test_flag();
    drive_idle();
    flagop = FLAG_OP_SET; nflag = 32'h1234_cdef; a4 = {4{5'd31}};
    #2;
    checks++;
    if (rd4[31:0] !== 32'h0) begin
      errors++; $display("FAIL flag_not_bypassed: got %h want 0", rd4[31:0]);
    end
    tick();
    drive_idle();
    #1;
    checks++;
    if (flag4 !== 32'h1234_cdef || flag2 !== 32'h1234_cdef || rd4[31:0] !== 32'h1234_cdef) begin
      errors++; $display("FAIL flag_set: got %h/%h/%h want 1234cdef", flag4, flag2, rd4[31:0]);
    end
    flagop = FLAG_OP_OR; nflag = 32'h0000_0010;
    tick();
    drive_idle();
    checks++;
    if (flag4 !== 32'h1234_cdff || flag2 !== 32'h1234_cdff) begin
      errors++; $display("FAIL flag_or: got %h/%h want 1234cdff", flag4, flag2);
    end
    flagop = FLAG_OP_SET_AND_WR; nflag = 32'h1212_3434;
    we0 = 1'b1; awr0 = 5'd21; din0 = 32'h9876_5432;
    tick();
    drive_idle(); a4 = {5'd0, 5'd0, 5'd21, 5'd31}; a2 = {5'd21, 5'd31};
    #1;
    checks++;
    if (flag4 !== 32'h1212_3434 || rd4[63:32] !== 32'h9876_5432 || rd2[63:32] !== 32'h9876_5432) begin
      errors++; $display("FAIL flag_set_and_wr: got %h/%h/%h want 12123434/98765432", flag4, rd4[63:32], rd2[63:32]);
    end
    flagop = FLAG_OP_SET; nflag = 32'h5555_5555;
    we1 = 1'b1; awr1 = 5'd31; din1 = 32'haaaa_aaaa;
    #1;
    checks++;
    if (rd4[31:0] !== 32'h1212_3434) begin
      errors++; $display("FAIL flag_addr_no_bypass: got %h want 12123434", rd4[31:0]);
    end
    tick();
    drive_idle();
    checks++;
    if (flag4 !== 32'h5555_5555 || flag2 !== 32'h5555_5555) begin
      errors++; $display("FAIL flag_beats_write: got %h/%h want 55555555", flag4, flag2);
    end
  endtask

  task automatic test_scoreboard();
    drive_idle();
    issue_en = 1'b1; issue_addr = 5'd3;
    tick();
    drive_idle(); a4 = {4{5'd3}}; a2 = {2{5'd3}};
    #2;
    checks++;
    if (rbusy4[0] !== 1'b1 || rbusy2[0] !== 1'b1) begin
      errors++; $display("FAIL sb_issue: got %b/%b want 1/1", rbusy4[0], rbusy2[0]);
    end
    we0 = 1'b1; awr0 = 5'd3; din0 = 32'h3333_0000; issue_en = 1'b1; issue_addr = 5'd3;
    #2;
    checks++;
    if (rbusy4[0] !== 1'b1) begin
      errors++; $display("FAIL sb_reissue_pre: got %b want 1", rbusy4[0]);
    end
    tick();
    drive_idle();
    #2;
    checks++;
    if (rbusy4[0] !== 1'b1 || rbusy2[0] !== 1'b1) begin
      errors++; $display("FAIL sb_set_wins: got %b/%b want 1/1", rbusy4[0], rbusy2[0]);
    end
    we0 = 1'b1; awr0 = 5'd3; din0 = 32'h3333_1111;
    #2;
    checks++;
    if (rbusy4[0] !== 1'b0 || rbusy2[0] !== 1'b1) begin
      errors++; $display("FAIL sb_clear_pre: got %b/%b want 0/1", rbusy4[0], rbusy2[0]);
    end
    tick();
    drive_idle();
    #2;
    checks++;
    if (rbusy4[0] !== 1'b0 || rbusy2[0] !== 1'b0) begin
      errors++; $display("FAIL sb_clear: got %b/%b want 0/0", rbusy4[0], rbusy2[0]);
    end
    issue_en = 1'b1; issue_addr = 5'd0; a4 = {4{5'd0}}; a2 = {2{5'd0}};
    tick();
    drive_idle();
    #2;
    checks++;
    if (rbusy4[0] !== 1'b0 || rbusy2[0] !== 1'b0) begin
      errors++; $display("FAIL sb_issue_r0: got %b/%b want 0/0", rbusy4[0], rbusy2[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      awr0 = pick_addr(); awr1 = pick_addr();
      din0 = $urandom; din1 = $urandom;
      flagop = 2'($urandom); nflag = $urandom;
      if (flagop == FLAG_OP_SET) begin
        we0 = 1'b0; we1 = 1'b0;
      end
      issue_en = 1'($urandom); issue_addr = pick_addr();
      a4 = {pick_addr(), pick_addr(), awr1, awr0};
      a2 = {pick_addr(), awr0};
      #2;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd4[k*32 +: 32] !== exp_rd(1, a4[k*5 +: 5]) || rbusy4[k] !== exp_busy(1, a4[k*5 +: 5])) begin
          errors++;
          $display("FAIL rand4 it%0d p%0d a%0d: got %h/%b want %h/%b", it, k, a4[k*5 +: 5],
                   rd4[k*32 +: 32], rbusy4[k], exp_rd(1, a4[k*5 +: 5]), exp_busy(1, a4[k*5 +: 5]));
        end
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rd2[k*32 +: 32] !== exp_rd(0, a2[k*5 +: 5]) || rbusy2[k] !== exp_busy(0, a2[k*5 +: 5])) begin
          errors++;
          $display("FAIL rand2 it%0d p%0d a%0d: got %h/%b want %h/%b", it, k, a2[k*5 +: 5],
                   rd2[k*32 +: 32], rbusy2[k], exp_rd(0, a2[k*5 +: 5]), exp_busy(0, a2[k*5 +: 5]));
        end
      end
      tick();
      checks++;
      if (flag4 !== m_regs[31] || flag2 !== m_regs[31]) begin
        errors++; $display("FAIL rand_flag it%0d: got %h/%h want %h", it, flag4, flag2, m_regs[31]);
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    a4 = 20'h0; a2 = 10'h0;
    model_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #10 reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    tick();
    test_dual_write();
    test_bypass();
    test_flag();
    test_scoreboard();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
